clause_array_io_ctrl: RTL and testbench

- Sequences the load and update ports of the clause array (the chain of clause cells with per-clause wr/rd strobes).
- Load: accepts a valid/ready stream of clauses and writes each into the next clause slot with a one-hot write strobe. Zero-fills unused slots so they read as empty and satisfied.
- Update: walks every slot with a one-hot read strobe, captures the shared clause readback bus and that slot's length, and streams them out.

---
 rtl/clause_array_io_ctrl_pkg.sv | 27 ++
 rtl/clause_array_io_ctrl_if.sv | 39 +++
 rtl/clause_array_io_ctrl_onehot_dec.sv | 23 ++
 rtl/clause_array_io_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_clause_array_io_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clause_array_io_ctrl_pkg.sv
// Shared types and helpers for the clause array load/update sequencer.
package clause_array_io_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FILL = 3'd2,
    ST_RD   = 3'd3,
    ST_OUT  = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  // Smallest slot-index width that can address n slots.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/clause_array_io_ctrl_if.sv
// Load stream, clause array port and update stream of the clause array sequencer.
interface clause_array_io_ctrl_if #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4
);
  logic                               load_valid_i;
  logic                               load_ready_o;
  logic [NUM_VARS*2-1:0]              load_clause_i;
  logic [WIDTH_C_LEN-1:0]             load_len_i;
  logic                               load_last_i;

  logic [NUM_CLAUSES-1:0]             wr_o;
  logic [NUM_CLAUSES-1:0]             rd_o;
  logic [NUM_VARS*2-1:0]              clause_o;
  logic [WIDTH_C_LEN-1:0]             clause_len_o;
  logic [NUM_VARS*2-1:0]              array_clause_i;
  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] array_len_i;

  logic                               upd_valid_o;
  logic                               upd_ready_i;
  logic [NUM_VARS*2-1:0]              upd_clause_o;
  logic [WIDTH_C_LEN-1:0]             upd_len_o;
  logic                               upd_last_o;

  modport master (
    input  load_valid_i, load_clause_i, load_len_i, load_last_i,
    input  array_clause_i, array_len_i, upd_ready_i,
    output load_ready_o, wr_o, rd_o, clause_o, clause_len_o,
    output upd_valid_o, upd_clause_o, upd_len_o, upd_last_o
  );

  modport slave (
    output load_valid_i, load_clause_i, load_len_i, load_last_i,
    output array_clause_i, array_len_i, upd_ready_i,
    input  load_ready_o, wr_o, rd_o, clause_o, clause_len_o,
    input  upd_valid_o, upd_clause_o, upd_len_o, upd_last_o
  );
endinterface

// File: rtl/clause_array_io_ctrl_onehot_dec.sv
// Gated binary-to-one-hot slot strobe decoder.
module clause_array_io_ctrl_onehot_dec #(
  parameter int WIDTH_CID   = 4,
  parameter int NUM_CLAUSES = 8
) (
  input  logic [WIDTH_CID-1:0]   i_idx,
  input  logic                   i_en,
  output logic [NUM_CLAUSES-1:0] o_onehot
);

  // One bit per slot, all zero when the strobe is not enabled.
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NUM_CLAUSES; k++) begin
      if (i_en && (i_idx == WIDTH_CID'(k))) begin
        o_onehot[k] = 1'b1;
      end else begin
        o_onehot[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/clause_array_io_ctrl.sv
// Load/update sequencer for the clause array: writes streamed clauses into slots
// with one-hot strobes, zero-fills the rest, and reads every slot back out.
module clause_array_io_ctrl
  import clause_array_io_ctrl_pkg::*;
#(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CID   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_load_i,
  input  logic                   start_update_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [WIDTH_CID:0]     nb_loaded_o,
  clause_array_io_ctrl_if.master bus
);

  localparam int CW  = NUM_VARS * 2;
  localparam int NBW = WIDTH_CID + 1;
  localparam logic [WIDTH_CID-1:0] LAST_IDX = WIDTH_CID'(NUM_CLAUSES - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [WIDTH_CID-1:0]   r_idx;
  logic [WIDTH_CID-1:0]   w_next_idx;

  logic [NUM_CLAUSES-1:0] r_wr;
  logic [CW-1:0]          r_clause;
  logic [WIDTH_C_LEN-1:0] r_clause_len;
  logic                   r_upd_valid;
  logic [CW-1:0]          r_upd_clause;
  logic [WIDTH_C_LEN-1:0] r_upd_len;
  logic                   r_upd_last;
  logic                   r_done;
  logic [NBW-1:0]         r_nb_loaded;

  logic                   w_idx_last;
  logic                   w_load_hs;
  logic                   w_load_exit;
  logic                   w_upd_hs;
  logic                   w_wr_en;
  logic                   w_rd_en;
  logic                   w_load_ready;
  logic [CW-1:0]          w_wr_clause;
  logic [WIDTH_C_LEN-1:0] w_wr_len;
  logic [WIDTH_C_LEN-1:0] w_len_sel;
  logic [NUM_CLAUSES-1:0] w_wr_onehot;
  logic [NUM_CLAUSES-1:0] w_rd_onehot;

  assign w_idx_last  = (r_idx == LAST_IDX);
  assign w_load_hs   = (r_state == ST_LOAD) && bus.load_valid_i;
  assign w_load_exit = w_load_hs && (bus.load_last_i || w_idx_last);
  assign w_upd_hs    = (r_state == ST_OUT) && r_upd_valid && bus.upd_ready_i;
  assign w_len_sel   = bus.array_len_i[int'(r_idx) * WIDTH_C_LEN +: WIDTH_C_LEN];

  // State and slot index register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  // Next-state and next-index selection.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (start_load_i) begin
          w_next_state = ST_LOAD;
          w_next_idx   = '0;
        end else if (start_update_i) begin
          w_next_state = ST_RD;
          w_next_idx   = '0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_load_exit) begin
          // A full array skips the fill pass entirely.
          if (w_idx_last) begin
            w_next_state = ST_FIN;
          end else begin
            w_next_state = ST_FILL;
            w_next_idx   = r_idx + WIDTH_CID'(1);
          end
        end else if (w_load_hs) begin
          w_next_idx = r_idx + WIDTH_CID'(1);
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_FILL: begin
        if (w_idx_last) begin
          w_next_state = ST_FIN;
        end else begin
          w_next_idx = r_idx + WIDTH_CID'(1);
        end
      end
      ST_RD: begin
        w_next_state = ST_OUT;
      end
      ST_OUT: begin
        if (w_upd_hs) begin
          if (r_upd_last) begin
            w_next_state = ST_FIN;
          end else begin
            w_next_state = ST_RD;
            w_next_idx   = r_idx + WIDTH_CID'(1);
          end
        end else begin
          w_next_state = ST_OUT;
        end
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
        w_next_idx   = '0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

  // Per-state strobe enables and write data.
  always_comb begin
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_load_ready = 1'b0;
    w_wr_clause  = '0;
    w_wr_len     = '0;
    case (r_state)
      ST_LOAD: begin
        w_load_ready = 1'b1;
        if (bus.load_valid_i) begin
          w_wr_en     = 1'b1;
          w_wr_clause = bus.load_clause_i;
          w_wr_len    = bus.load_len_i;
        end else begin
          w_wr_en = 1'b0;
        end
      end
      ST_FILL: begin
        w_wr_en = 1'b1;
      end
      ST_RD: begin
        w_rd_en = 1'b1;
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  clause_array_io_ctrl_onehot_dec #(
    .WIDTH_CID   (WIDTH_CID),
    .NUM_CLAUSES (NUM_CLAUSES)
  ) u_wr_dec (
    .i_idx    (r_idx),
    .i_en     (w_wr_en),
    .o_onehot (w_wr_onehot)
  );

  clause_array_io_ctrl_onehot_dec #(
    .WIDTH_CID   (WIDTH_CID),
    .NUM_CLAUSES (NUM_CLAUSES)
  ) u_rd_dec (
    .i_idx    (r_idx),
    .i_en     (w_rd_en),
    .o_onehot (w_rd_onehot)
  );

  // Registered write port, update beat, completion pulse and load count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr         <= '0;
      r_clause     <= '0;
      r_clause_len <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_clause <= '0;
      r_upd_len    <= '0;
      r_upd_last   <= 1'b0;
      r_done       <= 1'b0;
      r_nb_loaded  <= '0;
    end else begin
      r_wr         <= w_wr_onehot;
      r_clause     <= w_wr_clause;
      r_clause_len <= w_wr_len;
      r_done       <= (r_state == ST_FIN);
      if ((r_state == ST_IDLE) && start_load_i) begin
        r_nb_loaded <= '0;
      end else if (w_load_hs) begin
        r_nb_loaded <= r_nb_loaded + NBW'(1);
      end else begin
        r_nb_loaded <= r_nb_loaded;
      end
      // Readback bus is only meaningful while the read strobe is up.
      if (r_state == ST_RD) begin
        r_upd_valid  <= 1'b1;
        r_upd_clause <= bus.array_clause_i;
        r_upd_len    <= w_len_sel;
        r_upd_last   <= w_idx_last;
      end else if (w_upd_hs) begin
        r_upd_valid <= 1'b0;
      end else begin
        r_upd_valid <= r_upd_valid;
      end
    end
  end

  assign bus.load_ready_o = w_load_ready;
  assign bus.wr_o         = r_wr;
  assign bus.rd_o         = w_rd_onehot;
  assign bus.clause_o     = r_clause;
  assign bus.clause_len_o = r_clause_len;
  assign bus.upd_valid_o  = r_upd_valid;
  assign bus.upd_clause_o = r_upd_clause;
  assign bus.upd_len_o    = r_upd_len;
  assign bus.upd_last_o   = r_upd_last;
  assign busy_o           = (r_state != ST_IDLE);
  assign done_o           = r_done;
  assign nb_loaded_o      = r_nb_loaded;

endmodule

// File: tb/tb_clause_array_io_ctrl.sv
// Directed bench for clause_array_io_ctrl: cycle tables for load/fill/update,
// plus hand sequences for stall, start priority and asynchronous reset.
module tb_clause_array_io_ctrl;

  localparam int NV = 8;
  localparam int NC = 8;
  localparam int WL = 4;
  localparam int WC = 4;

  logic          clk;
  logic          rst;
  logic          start_load;
  logic          start_update;
  logic          busy;
  logic          done;
  logic [WC:0]   nb;

  int n_tests;
  int n_fail;

  clause_array_io_ctrl_if #(.NUM_VARS(NV), .NUM_CLAUSES(NC), .WIDTH_C_LEN(WL)) bus_if ();

  clause_array_io_ctrl #(
    .NUM_VARS(NV), .NUM_CLAUSES(NC), .WIDTH_C_LEN(WL), .WIDTH_CID(WC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_load_i   (start_load),
    .start_update_i (start_update),
    .busy_o         (busy),
    .done_o         (done),
    .nb_loaded_o    (nb),
    .bus            (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: slot k holds clause k+1 and length k+2.
  always_comb begin
    bus_if.array_clause_i = '0;
    bus_if.array_len_i    = '0;
    for (int k = 0; k < NC; k++) begin
      bus_if.array_len_i[k*WL +: WL] = WL'(k + 2);
      if (bus_if.rd_o[k]) begin
        bus_if.array_clause_i = bus_if.array_clause_i | 16'(k + 1);
      end
    end
  end

  typedef struct {
    logic        sl, su, lv, llast, ur;
    logic [15:0] lc;
    logic [3:0]  ll;
    logic        e_ready, e_uv, e_ulast, e_busy, e_done;
    logic [7:0]  e_wr, e_rd;
    logic [15:0] e_clause, e_uc;
    logic [3:0]  e_len, e_ul;
    logic [4:0]  e_nb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t blank();
    vec_t v;
    v.sl = 1'b0; v.su = 1'b0; v.lv = 1'b0; v.llast = 1'b0; v.ur = 1'b0;
    v.lc = 16'h0000; v.ll = 4'd0;
    v.e_ready = 1'b0; v.e_uv = 1'b0; v.e_ulast = 1'b0; v.e_busy = 1'b0; v.e_done = 1'b0;
    v.e_wr = 8'h00; v.e_rd = 8'h00; v.e_clause = 16'h0000; v.e_uc = 16'h0000;
    v.e_len = 4'd0; v.e_ul = 4'd0; v.e_nb = 5'd0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input int i);
    @(posedge clk);
    #1;
    start_load                = v.sl;
    start_update              = v.su;
    bus_if.load_valid_i       = v.lv;
    bus_if.load_clause_i      = v.lc;
    bus_if.load_len_i         = v.ll;
    bus_if.load_last_i        = v.llast;
    bus_if.upd_ready_i        = v.ur;
    #1;
    chk($sformatf("row%0d.ready", i), 32'(bus_if.load_ready_o), 32'(v.e_ready));
    chk($sformatf("row%0d.wr", i), 32'(bus_if.wr_o), 32'(v.e_wr));
    chk($sformatf("row%0d.rd", i), 32'(bus_if.rd_o), 32'(v.e_rd));
    chk($sformatf("row%0d.clause", i), 32'(bus_if.clause_o), 32'(v.e_clause));
    chk($sformatf("row%0d.clause_len", i), 32'(bus_if.clause_len_o), 32'(v.e_len));
    chk($sformatf("row%0d.upd_valid", i), 32'(bus_if.upd_valid_o), 32'(v.e_uv));
    chk($sformatf("row%0d.upd_clause", i), 32'(bus_if.upd_clause_o), 32'(v.e_uc));
    chk($sformatf("row%0d.upd_len", i), 32'(bus_if.upd_len_o), 32'(v.e_ul));
    chk($sformatf("row%0d.upd_last", i), 32'(bus_if.upd_last_o), 32'(v.e_ulast));
    chk($sformatf("row%0d.busy", i), 32'(busy), 32'(v.e_busy));
    chk($sformatf("row%0d.done", i), 32'(done), 32'(v.e_done));
    chk($sformatf("row%0d.nb_loaded", i), 32'(nb), 32'(v.e_nb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   c;
    int   nexp;
    int   nfill;
    bit   fin;

    n_tests = 0;
    n_fail  = 0;

    // Load 3 clauses then zero-fill 5 slots.
    v = blank(); v.sl = 1'b1; tbl.push_back(v);
    v = blank(); v.lv = 1'b1; v.lc = 16'h0006; v.ll = 4'd2; v.e_ready = 1'b1; v.e_busy = 1'b1;
    tbl.push_back(v);
    v = blank(); v.lv = 1'b1; v.lc = 16'h0018; v.ll = 4'd2; v.e_ready = 1'b1; v.e_busy = 1'b1;
    v.e_wr = 8'h01; v.e_clause = 16'h0006; v.e_len = 4'd2; v.e_nb = 5'd1; tbl.push_back(v);
    v = blank(); v.lv = 1'b1; v.lc = 16'h0041; v.ll = 4'd2; v.llast = 1'b1; v.e_ready = 1'b1;
    v.e_busy = 1'b1; v.e_wr = 8'h02; v.e_clause = 16'h0018; v.e_len = 4'd2; v.e_nb = 5'd2;
    tbl.push_back(v);
    v = blank(); v.e_busy = 1'b1; v.e_wr = 8'h04; v.e_clause = 16'h0041; v.e_len = 4'd2;
    v.e_nb = 5'd3; tbl.push_back(v);
    for (int i = 3; i < 8; i++) begin
      v = blank(); v.e_busy = 1'b1; v.e_wr = 8'(1 << i); v.e_nb = 5'd3; tbl.push_back(v);
    end
    v = blank(); v.e_done = 1'b1; v.e_nb = 5'd3; tbl.push_back(v);
    v = blank(); v.e_nb = 5'd3; tbl.push_back(v);

    // Load 8 back-to-back clauses, 9th beat offered but refused.
    v = blank(); v.sl = 1'b1; v.e_nb = 5'd3; tbl.push_back(v);
    for (int k = 0; k <= 8; k++) begin
      v = blank(); v.lv = 1'b1; v.lc = 16'hA000 | 16'(k); v.ll = 4'(k + 1);
      v.e_busy = 1'b1; v.e_ready = (k < 8); v.e_nb = 5'(k);
      if (k > 0) begin
        v.e_wr = 8'(1 << (k - 1)); v.e_clause = 16'hA000 | 16'(k - 1); v.e_len = 4'(k);
      end
      tbl.push_back(v);
    end
    v = blank(); v.lv = 1'b1; v.lc = 16'hA008; v.e_done = 1'b1; v.e_nb = 5'd8; tbl.push_back(v);
    v = blank(); v.e_nb = 5'd8; tbl.push_back(v);

    // Full update walk with downstream always ready.
    v = blank(); v.su = 1'b1; v.ur = 1'b1; v.e_nb = 5'd8; tbl.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v = blank(); v.ur = 1'b1; v.e_nb = 5'd8; v.e_busy = 1'b1; v.e_rd = 8'(1 << k);
      v.e_uc = (k == 0) ? 16'h0000 : 16'(k); v.e_ul = (k == 0) ? 4'd0 : 4'(k + 1);
      tbl.push_back(v);
      v = blank(); v.ur = 1'b1; v.e_nb = 5'd8; v.e_busy = 1'b1; v.e_uv = 1'b1;
      v.e_uc = 16'(k + 1); v.e_ul = 4'(k + 2); v.e_ulast = (k == 7); tbl.push_back(v);
    end
    v = blank(); v.ur = 1'b1; v.e_nb = 5'd8; v.e_busy = 1'b1; v.e_uc = 16'd8; v.e_ul = 4'd9;
    v.e_ulast = 1'b1; tbl.push_back(v);
    v = blank(); v.ur = 1'b1; v.e_nb = 5'd8; v.e_done = 1'b1; v.e_uc = 16'd8; v.e_ul = 4'd9;
    v.e_ulast = 1'b1; tbl.push_back(v);

    rst = 1'b0; start_load = 1'b0; start_update = 1'b0;
    bus_if.load_valid_i = 1'b0; bus_if.load_clause_i = '0; bus_if.load_len_i = '0;
    bus_if.load_last_i = 1'b0; bus_if.upd_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.wr", 32'(bus_if.wr_o), 32'd0);
    chk("reset.rd", 32'(bus_if.rd_o), 32'd0);
    chk("reset.ready", 32'(bus_if.load_ready_o), 32'd0);
    chk("reset.upd_valid", 32'(bus_if.upd_valid_o), 32'd0);
    chk("reset.nb_loaded", 32'(nb), 32'd0);
    #2 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_row(tbl[i], i);
    end

    // Stall beat 2 for 5 cycles; every slot must be handed over exactly once, in order.
    @(posedge clk); #1;
    start_update = 1'b1; bus_if.upd_ready_i = 1'b1;
    nexp = 1; c = 0; fin = 1'b0;
    while (!fin && c < 100) begin
      @(posedge clk); #1;
      start_update = 1'b0;
      c++;
      bus_if.upd_ready_i = !(c >= 4 && c <= 8);
      if (c >= 4 && c <= 8) begin
        chk($sformatf("stall%0d.upd_valid", c), 32'(bus_if.upd_valid_o), 32'd1);
        chk($sformatf("stall%0d.upd_clause", c), 32'(bus_if.upd_clause_o), 32'd2);
        chk($sformatf("stall%0d.upd_len", c), 32'(bus_if.upd_len_o), 32'd3);
        chk($sformatf("stall%0d.rd", c), 32'(bus_if.rd_o), 32'd0);
      end
      if (bus_if.upd_valid_o && bus_if.upd_ready_i) begin
        chk($sformatf("stall.hs_clause%0d", nexp), 32'(bus_if.upd_clause_o), 32'(nexp));
        nexp++;
      end
      if (done) fin = 1'b1;
    end
    chk("stall.done_seen", 32'(fin), 32'd1);
    chk("stall.beats", 32'(nexp - 1), 32'd8);

    // Simultaneous starts: load wins; a later start_update is ignored.
    @(posedge clk); #1;
    start_load = 1'b1; start_update = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0; start_update = 1'b1;
    #1;
    chk("both.ready", 32'(bus_if.load_ready_o), 32'd1);
    chk("both.rd", 32'(bus_if.rd_o), 32'd0);
    @(posedge clk); #1;
    start_update = 1'b0;
    bus_if.load_valid_i = 1'b1; bus_if.load_clause_i = 16'hBEEF; bus_if.load_len_i = 4'd5;
    bus_if.load_last_i = 1'b1;
    #1;
    chk("ignored.ready", 32'(bus_if.load_ready_o), 32'd1);
    chk("ignored.rd", 32'(bus_if.rd_o), 32'd0);
    @(posedge clk); #1;
    bus_if.load_valid_i = 1'b0; bus_if.load_last_i = 1'b0;
    #1;
    chk("both.wr", 32'(bus_if.wr_o), 32'h01);
    chk("both.clause", 32'(bus_if.clause_o), 32'hBEEF);
    chk("both.clause_len", 32'(bus_if.clause_len_o), 32'd5);
    nfill = 0; fin = 1'b0; c = 0;
    while (!fin && c < 20) begin
      @(posedge clk); #1;
      c++;
      if (bus_if.wr_o != 8'h00 && bus_if.clause_o == 16'h0000) nfill++;
      if (done) fin = 1'b1;
    end
    chk("both.done_seen", 32'(fin), 32'd1);
    chk("both.fill_writes", 32'(nfill), 32'd7);
    chk("both.nb_loaded", 32'(nb), 32'd1);

    // Asynchronous reset in the read cycle of beat 2.
    @(posedge clk); #1;
    start_update = 1'b1;
    @(posedge clk); #1;
    start_update = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.pre_rd", 32'(bus_if.rd_o), 32'h02);
    chk("rst.pre_upd_clause", 32'(bus_if.upd_clause_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst.rd", 32'(bus_if.rd_o), 32'd0);
    chk("rst.wr", 32'(bus_if.wr_o), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.upd_valid", 32'(bus_if.upd_valid_o), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.upd_clause", 32'(bus_if.upd_clause_o), 32'd0);
    chk("rst.nb_loaded", 32'(nb), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("post.busy", 32'(busy), 32'd0);
    chk("post.ready", 32'(bus_if.load_ready_o), 32'd0);
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    bus_if.load_valid_i = 1'b1; bus_if.load_clause_i = 16'h0003; bus_if.load_len_i = 4'd1;
    bus_if.load_last_i = 1'b1;
    #1;
    chk("post.ready_load", 32'(bus_if.load_ready_o), 32'd1);
    @(posedge clk); #1;
    bus_if.load_valid_i = 1'b0; bus_if.load_last_i = 1'b0;
    #1;
    chk("post.wr", 32'(bus_if.wr_o), 32'h01);
    chk("post.clause", 32'(bus_if.clause_o), 32'h0003);
    fin = 1'b0; c = 0;
    while (!fin && c < 20) begin
      @(posedge clk); #1;
      c++;
      if (done) fin = 1'b1;
    end
    chk("post.done_seen", 32'(fin), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
